// File: rtl/md5_msg_pad.sv
// md5_msg_pad: MD5 message padder; accepts a byte stream and emits 512-bit blocks as 16 little-endian words.
// Defining MD5_PAD_BLKCNT_EN adds blk_cnt_o, the index of the current block within its message.
module md5_msg_pad #(
  parameter int n     = 32,
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   data_i,
  input  logic         keep_i,
  input  logic         valid_i,
  input  logic         last_i,
  output logic         ready_o,
  output logic [n-1:0] M_o [0:15],
  output logic         blk_valid_o,
  output logic         blk_last_o,
`ifdef MD5_PAD_BLKCNT_EN
  output logic [15:0]  blk_cnt_o,
`endif
  input  logic         blk_ready_i
);

  typedef enum logic [1:0] {FILL, PAD, EMIT, LEN} state_t;

  state_t           state, state_nxt;
  logic [5:0]       ptr;
  logic [LEN_W-1:0] len;
  logic             pend_last, pend_len, last_q;
  logic [n-1:0]     words [0:15];
  logic             take_byte, hs;

  // Bit length zero-extended to 64 bits, split into the two trailing words.
  function automatic logic [n-1:0] len_word(input logic [LEN_W-1:0] l, input logic hi);
    logic [63:0] x;
    x = '0;
    x[LEN_W-1:0] = l;
    return hi ? n'(x[63:32]) : n'(x[31:0]);
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    blk_valid_o = 1'b0;
    take_byte   = 1'b0;
    hs          = 1'b0;
    unique case (state)
      FILL: begin
        ready_o   = 1'b1;
        take_byte = valid_i & keep_i;
        if (take_byte && ptr == 6'd63) state_nxt = EMIT;
        else if (valid_i && last_i)    state_nxt = PAD;
      end
      PAD: state_nxt = EMIT;
      EMIT: begin
        blk_valid_o = 1'b1;
        hs          = blk_ready_i;
        if (hs) begin
          if (pend_last)     state_nxt = PAD;
          else if (pend_len) state_nxt = LEN;
          else               state_nxt = FILL;
        end
      end
      LEN: state_nxt = EMIT;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr       <= '0;
      len       <= '0;
      pend_last <= 1'b0;
      pend_len  <= 1'b0;
      last_q    <= 1'b0;
      for (int i = 0; i < 16; i++) words[i] <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (take_byte) begin
            words[ptr[5:2]][{ptr[1:0], 3'b000} +: 8] <= data_i;
            ptr <= ptr + 6'd1;
            len <= len + LEN_W'(8);
            if (ptr == 6'd63) pend_last <= last_i;
          end
        end
        PAD: begin
          words[ptr[5:2]][{ptr[1:0], 3'b000} +: 8] <= 8'h80;
          // Length only fits when the 0x80 marker lands before byte 56.
          if (ptr <= 6'd55) begin
            words[14] <= len_word(len, 1'b0);
            words[15] <= len_word(len, 1'b1);
            last_q    <= 1'b1;
          end else begin
            last_q   <= 1'b0;
            pend_len <= 1'b1;
          end
        end
        EMIT: begin
          if (hs) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            ptr    <= '0;
            last_q <= 1'b0;
            if (pend_last)     pend_last <= 1'b0;
            else if (pend_len) pend_len  <= 1'b0;
            else if (last_q)   len       <= '0;
          end
        end
        LEN: begin
          words[14] <= len_word(len, 1'b0);
          words[15] <= len_word(len, 1'b1);
          last_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign M_o        = words;
  assign blk_last_o = last_q;

`ifdef MD5_PAD_BLKCNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                         blk_cnt_o <= '0;
    else if (hs && last_q)              blk_cnt_o <= '0;
    else if (hs && blk_cnt_o != 16'hFFFF) blk_cnt_o <= blk_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_md5_msg_pad.sv
// Self-checking bench for md5_msg_pad: directed scenarios plus random messages against a padding model.
module tb_md5_msg_pad;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        keep_i = 1'b0, valid_i = 1'b0, last_i = 1'b0, blk_ready_i = 1'b0;
  logic        ready_o, blk_valid_o, blk_last_o;
  logic [31:0] M_o [0:15];
`ifdef MD5_PAD_BLKCNT_EN
  logic [15:0] blk_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [511:0] d;
    bit           last;
  } blk_t;
  blk_t exp_q[$];

  always #5 clk_i = ~clk_i;

  md5_msg_pad #(.n(32), .LEN_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .keep_i(keep_i),
    .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o), .M_o(M_o),
    .blk_valid_o(blk_valid_o), .blk_last_o(blk_last_o),
`ifdef MD5_PAD_BLKCNT_EN
    .blk_cnt_o(blk_cnt_o),
`endif
    .blk_ready_i(blk_ready_i)
  );

  // Standard MD5 padding of a whole message, cut into 64-byte blocks.
  function automatic void model(input logic [7:0] msg[$]);
    logic [7:0] p[$];
    longint unsigned bits;
    blk_t b;
    p = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (8 * i)));
    exp_q.delete();
    for (int k = 0; k < p.size() / 64; k++) begin
      b.d = '0;
      for (int j = 0; j < 64; j++) b.d[8*j +: 8] = p[64*k + j];
      b.last = (k == p.size() / 64 - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic run_msg(input logic [7:0] msg[$], input bit rnd, input string tag);
    int bi = 0;
    int nb = 0;
    int cyc = 0;
    int n_beats;
    bit real_beat;
    n_beats = (msg.size() == 0) ? 1 : msg.size();
    model(msg);
    while (nb < exp_q.size() && cyc < 4000) begin
      real_beat = 0; valid_i = 0; keep_i = 0; last_i = 0; data_i = 8'h00;
      if (bi < n_beats) begin
        if (!rnd || $urandom_range(3) != 0) begin
          valid_i = 1; real_beat = 1; keep_i = (msg.size() != 0);
          if (msg.size() != 0) data_i = msg[bi];
          last_i = (bi == n_beats - 1);
        end else if ($urandom_range(1) == 1) begin
          valid_i = 1; data_i = 8'($urandom);
        end
      end
      blk_ready_i = rnd ? 1'($urandom_range(1)) : 1'b1;
      if (blk_valid_o === 1'b1) begin
        total++;
        if (ready_o !== 1'b0) begin
          bad++; $display("FAIL %s ready_in_emit got=%b exp=0", tag, ready_o);
        end
        if (blk_ready_i) begin
          for (int w = 0; w < 16; w++) begin
            total++;
            if (M_o[w] !== exp_q[nb].d[32*w +: 32]) begin
              bad++; $display("FAIL %s blk%0d word%0d got=%h exp=%h", tag, nb, w, M_o[w], exp_q[nb].d[32*w +: 32]);
            end
          end
          total++;
          if (blk_last_o !== exp_q[nb].last) begin
            bad++; $display("FAIL %s blk%0d last got=%b exp=%b", tag, nb, blk_last_o, exp_q[nb].last);
          end
`ifdef MD5_PAD_BLKCNT_EN
          total++;
          if (blk_cnt_o !== 16'(nb)) begin
            bad++; $display("FAIL %s blk%0d cnt got=%0d exp=%0d", tag, nb, blk_cnt_o, nb);
          end
`endif
          nb++;
        end
      end
      if (real_beat && ready_o === 1'b1) bi++;
      @(negedge clk_i);
      cyc++;
    end
    valid_i = 0; keep_i = 0; last_i = 0; blk_ready_i = 0;
    total++;
    if (nb < exp_q.size()) begin
      bad++; $display("FAIL %s timeout blocks got=%0d exp=%0d", tag, nb, exp_q.size());
    end
    total++;
    if (ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin
      bad++; $display("FAIL %s idle_after got ready=%b valid=%b exp ready=1 valid=0", tag, ready_o, blk_valid_o);
    end
`ifdef MD5_PAD_BLKCNT_EN
    total++;
    if (blk_cnt_o !== 16'd0) begin
      bad++; $display("FAIL %s cnt_after got=%0d exp=0", tag, blk_cnt_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst_i = 0;
    @(negedge clk_i); @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1 || blk_valid_o !== 1'b0 || blk_last_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got ready=%b valid=%b last=%b exp 1/0/0", ready_o, blk_valid_o, blk_last_o);
    end
    for (int w = 0; w < 16; w++) begin
      total++;
      if (M_o[w] !== 32'h0) begin
        bad++; $display("FAIL reset_word%0d got=%h exp=0", w, M_o[w]);
      end
    end
`ifdef MD5_PAD_BLKCNT_EN
    total++;
    if (blk_cnt_o !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", blk_cnt_o);
    end
`endif
    rst_i = 1;
    @(negedge clk_i);
  endtask

  task automatic test_empty();
    logic [7:0] m[$];
    run_msg(m, 1'b0, "empty");
  endtask

  task automatic test_abc(input string tag);
    logic [7:0] s [3];
    logic [31:0] e;
    s = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; keep_i = 1; data_i = s[i]; last_i = (i == 2);
      @(negedge clk_i);
    end
    valid_i = 0; keep_i = 0; last_i = 0;
    total++;
    if (blk_valid_o !== 1'b0) begin
      bad++; $display("FAIL %s pad_cycle_valid got=%b exp=0", tag, blk_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1 || ready_o !== 1'b0) begin
      bad++; $display("FAIL %s emit got valid=%b last=%b ready=%b exp 1/1/0", tag, blk_valid_o, blk_last_o, ready_o);
    end
    for (int w = 0; w < 16; w++) begin
      e = (w == 0) ? 32'h80636261 : (w == 14) ? 32'h18 : 32'h0;
      total++;
      if (M_o[w] !== e) begin
        bad++; $display("FAIL %s word%0d got=%h exp=%h", tag, w, M_o[w], e);
      end
    end
    blk_ready_i = 1;
    @(negedge clk_i);
    blk_ready_i = 0;
    total++;
    if (blk_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL %s after_hs got valid=%b ready=%b exp 0/1", tag, blk_valid_o, ready_o);
    end
  endtask

  task automatic test_56zero();
    logic [31:0] e;
    for (int i = 0; i < 56; i++) begin
      valid_i = 1; keep_i = 1; data_i = 8'h00; last_i = (i == 55);
      @(negedge clk_i);
    end
    valid_i = 0; keep_i = 0; last_i = 0;
    @(negedge clk_i);
    total++;
    if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b0) begin
      bad++; $display("FAIL z56 blk0 got valid=%b last=%b exp 1/0", blk_valid_o, blk_last_o);
    end
    for (int w = 0; w < 16; w++) begin
      e = (w == 14) ? 32'h80 : 32'h0;
      total++;
      if (M_o[w] !== e) begin
        bad++; $display("FAIL z56 blk0 word%0d got=%h exp=%h", w, M_o[w], e);
      end
    end
    blk_ready_i = 1;
    @(negedge clk_i);
    blk_ready_i = 0;
    total++;
    if (blk_valid_o !== 1'b0) begin
      bad++; $display("FAIL z56 len_cycle_valid got=%b exp=0", blk_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1) begin
      bad++; $display("FAIL z56 blk1 got valid=%b last=%b exp 1/1", blk_valid_o, blk_last_o);
    end
    for (int w = 0; w < 16; w++) begin
      e = (w == 14) ? 32'h1C0 : 32'h0;
      total++;
      if (M_o[w] !== e) begin
        bad++; $display("FAIL z56 blk1 word%0d got=%h exp=%h", w, M_o[w], e);
      end
    end
    blk_ready_i = 1;
    @(negedge clk_i);
    blk_ready_i = 0;
  endtask

  task automatic test_64ff();
    logic [7:0] m[$];
    repeat (64) m.push_back(8'hFF);
    run_msg(m, 1'b0, "ff64");
  endtask

  task automatic test_stall_reset();
    logic [7:0]  b  [64];
    logic [31:0] ew [16];
    for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
    for (int w = 0; w < 16; w++) ew[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
    for (int i = 0; i < 64; i++) begin
      valid_i = 1; keep_i = 1; data_i = b[i]; last_i = 0;
      @(negedge clk_i);
    end
    data_i = 8'hAA; last_i = 1;
    blk_ready_i = 0;
    repeat (10) begin
      total++;
      if (blk_valid_o !== 1'b1 || ready_o !== 1'b0 || blk_last_o !== 1'b0) begin
        bad++; $display("FAIL stall ctrl got valid=%b ready=%b last=%b exp 1/0/0", blk_valid_o, ready_o, blk_last_o);
      end
      for (int w = 0; w < 16; w++) begin
        total++;
        if (M_o[w] !== ew[w]) begin
          bad++; $display("FAIL stall word%0d got=%h exp=%h", w, M_o[w], ew[w]);
        end
      end
      @(negedge clk_i);
    end
    valid_i = 0; keep_i = 0; last_i = 0;
    #2 rst_i = 0;
    #1;
    total++;
    if (blk_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL async_reset got valid=%b ready=%b exp 0/1", blk_valid_o, ready_o);
    end
    for (int w = 0; w < 16; w++) begin
      total++;
      if (M_o[w] !== 32'h0) begin
        bad++; $display("FAIL async_reset word%0d got=%h exp=0", w, M_o[w]);
      end
    end
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    test_abc("abc_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    int lens [14];
    lens = '{55, 56, 63, 64, 119, 120, 128, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 7; k < 14; k++) lens[k] = $urandom_range(0, 140);
    for (int k = 0; k < 14; k++) begin
      m.delete();
      repeat (lens[k]) m.push_back(8'($urandom));
      run_msg(m, 1'b1, $sformatf("rand%0d_len%0d", k, lens[k]));
    end
  endtask

`ifdef MD5_PAD_BLKCNT_EN
  task automatic test_blkcnt();
    logic [7:0] m[$];
    repeat (130) m.push_back(8'($urandom));
    run_msg(m, 1'b0, "blkcnt130");
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_abc("abc");
    test_56zero();
    test_64ff();
    test_stall_reset();
    test_random();
`ifdef MD5_PAD_BLKCNT_EN
    test_blkcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
